dsa_mem_banked_simd: RTL and testbench

//   Parametrised N-bank pixel memory for the bilinear DSA: scalar + SIMD read and write ports.

---
 rtl/dsa_mem_banked_simd.sv | 158 +++++++++++++++
 tb/tb_dsa_mem_banked_simd.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsa_mem_banked_simd.sv
// N-bank pixel memory for the bilinear DSA: scalar and SIMD read/write ports.
// Pixel p lives in bank p[LW-1:0] at row p>>LW. Rows wrap modulo ROWS. Reads have a 2-cycle latency.
module dsa_mem_banked_simd #(
    parameter int DATA_W     = 8,
    parameter int NUM_BANKS  = 4,
    parameter int MEM_SIZE   = 262144,
    parameter int ADDR_WIDTH = 18
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rd_req_i,
    input  logic [ADDR_WIDTH-1:0]       rd_addr_i,
    output logic                        rd_ready_o,
    output logic                        rd_valid_o,
    output logic [DATA_W-1:0]           rd_data_o,
    input  logic                        vrd_req_i,
    input  logic [ADDR_WIDTH-1:0]       vrd_addr_i,
    output logic                        vrd_valid_o,
    output logic [NUM_BANKS*DATA_W-1:0] vrd_data_o,
    input  logic                        wr_en_i,
    input  logic [ADDR_WIDTH-1:0]       wr_addr_i,
    input  logic [DATA_W-1:0]           wr_data_i,
    output logic                        wr_ready_o,
    input  logic                        vwr_en_i,
    input  logic [ADDR_WIDTH-1:0]       vwr_addr_i,
    input  logic [NUM_BANKS-1:0]        vwr_mask_i,
    input  logic [NUM_BANKS*DATA_W-1:0] vwr_data_i,
    output logic [15:0]                 conflict_cnt_o
);
    localparam int LW   = $clog2(NUM_BANKS);
    localparam int RW   = ADDR_WIDTH - LW;
    localparam int ROWS = MEM_SIZE / NUM_BANKS;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    function automatic logic [RW-1:0] row_next(input logic [RW-1:0] r);
        return (r == LAST_ROW) ? '0 : r + RW'(1);
    endfunction

    logic [LW-1:0] vrd_off, vwr_off, rd_lane, wr_lane, wr_vlane;
    logic [RW-1:0] vrd_row, vrd_row_n, vwr_row, vwr_row_n, rd_row, wr_row;
    logic          rd_acc;
    logic [1:0]    stall_inc;
    logic [16:0]   cnt_sum;
    logic [15:0]   cnt_d, cnt_q;

    assign vrd_off   = vrd_addr_i[LW-1:0];
    assign vwr_off   = vwr_addr_i[LW-1:0];
    assign rd_lane   = rd_addr_i[LW-1:0];
    assign wr_lane   = wr_addr_i[LW-1:0];
    assign vrd_row   = vrd_addr_i[ADDR_WIDTH-1:LW];
    assign vwr_row   = vwr_addr_i[ADDR_WIDTH-1:LW];
    assign rd_row    = rd_addr_i[ADDR_WIDTH-1:LW];
    assign wr_row    = wr_addr_i[ADDR_WIDTH-1:LW];
    assign vrd_row_n = row_next(vrd_row);
    assign vwr_row_n = row_next(vwr_row);

    // A scalar write stalls only when the SIMD lane mapped onto its bank is enabled.
    assign wr_vlane   = wr_lane - vwr_off;
    assign wr_ready_o = !(vwr_en_i && vwr_mask_i[wr_vlane]);
    assign rd_ready_o = !vrd_req_i;
    assign rd_acc     = rd_req_i && !vrd_req_i;

    logic [NUM_BANKS*DATA_W-1:0] bank_rd;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        localparam logic [LW-1:0] BL = LW'(g);
        logic [DATA_W-1:0] ram [ROWS];
        logic [LW-1:0]     k;
        logic [RW-1:0]     raddr, waddr;
        logic [DATA_W-1:0] wdata, rdata_q;
        logic              we;

        // Banks below the SIMD offset hold the lanes that spill into the next row.
        assign k     = BL - vwr_off;
        assign raddr = vrd_req_i ? ((BL < vrd_off) ? vrd_row_n : vrd_row) : rd_row;

        // Write steering: SIMD owns the bank when its lane is enabled, otherwise the scalar port may write.
        always_comb begin
            we    = 1'b0;
            waddr = wr_row;
            wdata = wr_data_i;
            if (vwr_en_i && vwr_mask_i[k]) begin
                we    = 1'b1;
                waddr = (BL < vwr_off) ? vwr_row_n : vwr_row;
                wdata = vwr_data_i[k*DATA_W +: DATA_W];
            end else begin
                we    = wr_en_i && (wr_lane == BL);
            end
        end

        // Bank RAM: one synchronous read and one write per cycle. A read returns the old data.
        always_ff @(posedge clk_i) begin
            if (we) begin
                ram[waddr] <= wdata;
            end
            rdata_q <= ram[raddr];
        end

        assign bank_rd[g*DATA_W +: DATA_W] = rdata_q;
    end

    logic                        s1_vld_q, s1_vec_q;
    logic [LW-1:0]               s1_sel_q, rot_idx;
    logic [NUM_BANKS*DATA_W-1:0] vrd_rot, vrd_data_q;
    logic [DATA_W-1:0]           rd_pick, rd_data_q;
    logic                        rd_valid_q, vrd_valid_q;

    // Reorder the bank data into lane order, using the registered offset.
    always_comb begin
        vrd_rot = '0;
        rot_idx = '0;
        for (int j = 0; j < NUM_BANKS; j++) begin
            rot_idx = s1_sel_q + LW'(j);
            vrd_rot[j*DATA_W +: DATA_W] = bank_rd[rot_idx*DATA_W +: DATA_W];
        end
    end

    assign rd_pick = bank_rd[s1_sel_q*DATA_W +: DATA_W];

    // Saturating stall counter. Both ports stalling in the same cycle adds two.
    assign stall_inc = {1'b0, rd_req_i && !rd_ready_o} + {1'b0, wr_en_i && !wr_ready_o};
    assign cnt_sum   = {1'b0, cnt_q} + {15'd0, stall_inc};
    assign cnt_d     = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    // Read pipeline control, output registers and counter. Reset drops any read still in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q    <= 1'b0;
            s1_vec_q    <= 1'b0;
            s1_sel_q    <= '0;
            rd_valid_q  <= 1'b0;
            vrd_valid_q <= 1'b0;
            rd_data_q   <= '0;
            vrd_data_q  <= '0;
            cnt_q       <= 16'd0;
        end else begin
            s1_vld_q    <= rd_acc || vrd_req_i;
            s1_vec_q    <= vrd_req_i;
            s1_sel_q    <= vrd_req_i ? vrd_off : rd_lane;
            rd_valid_q  <= s1_vld_q && !s1_vec_q;
            vrd_valid_q <= s1_vld_q && s1_vec_q;
            if (s1_vld_q && !s1_vec_q) begin
                rd_data_q <= rd_pick;
            end
            if (s1_vld_q && s1_vec_q) begin
                vrd_data_q <= vrd_rot;
            end
            cnt_q       <= cnt_d;
        end
    end

    assign rd_valid_o     = rd_valid_q;
    assign rd_data_o      = rd_data_q;
    assign vrd_valid_o    = vrd_valid_q;
    assign vrd_data_o     = vrd_data_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_dsa_mem_banked_simd.sv
// Scoreboard bench for dsa_mem_banked_simd: a pixel-memory model predicts read data, ready and stall count.
module tb_dsa_mem_banked_simd;
    localparam int DW = 8;
    localparam int NB = 4;
    localparam int MS = 262144;
    localparam int AW = 18;

    logic           clk = 1'b0;
    logic           rst;
    logic           rd_req, rd_ready, rd_valid;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;
    logic           vrd_req, vrd_valid;
    logic [AW-1:0]  vrd_addr;
    logic [NB*DW-1:0] vrd_data;
    logic           wr_en, wr_ready;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic           vwr_en;
    logic [AW-1:0]  vwr_addr;
    logic [NB-1:0]  vwr_mask;
    logic [NB*DW-1:0] vwr_data;
    logic [15:0]    conflict_cnt;

    int errors = 0;
    int checks = 0;
    longint cyc = 0;
    int cnt_m = 0;
    logic [7:0] mem_m [int];
    longint qv_due[$];
    logic [31:0] qv_data[$];
    longint qs_due[$];
    logic [7:0] qs_data[$];

    dsa_mem_banked_simd #(.DATA_W(DW), .NUM_BANKS(NB), .MEM_SIZE(MS), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .vrd_req_i(vrd_req), .vrd_addr_i(vrd_addr), .vrd_valid_o(vrd_valid), .vrd_data_o(vrd_data),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .vwr_en_i(vwr_en), .vwr_addr_i(vwr_addr), .vwr_mask_i(vwr_mask), .vwr_data_i(vwr_data),
        .conflict_cnt_o(conflict_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pop the scoreboard whenever an output is valid. Flag outputs that arrive late, early, or are missing.
    always @(negedge clk) begin
        if (vrd_valid) begin
            checks++;
            if (qv_due.size() == 0) begin
                errors++;
                $display("FAIL vrd_unexpected: got vrd_valid data=%h at cycle %0d, required no output", vrd_data, cyc);
            end else begin
                longint d;
                logic [31:0] e;
                d = qv_due.pop_front();
                e = qv_data.pop_front();
                if (d != cyc || vrd_data !== e) begin
                    errors++;
                    $display("FAIL vrd_data: got %h at cycle %0d, required %h at cycle %0d", vrd_data, cyc, e, d);
                end
            end
        end
        if (qv_due.size() > 0 && qv_due[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL vrd_missing: got no vrd_valid, required %h at cycle %0d", qv_data[0], qv_due[0]);
            void'(qv_due.pop_front());
            void'(qv_data.pop_front());
        end
        if (rd_valid) begin
            checks++;
            if (qs_due.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got rd_valid data=%h at cycle %0d, required no output", rd_data, cyc);
            end else begin
                longint d;
                logic [7:0] e;
                d = qs_due.pop_front();
                e = qs_data.pop_front();
                if (d != cyc || rd_data !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %h at cycle %0d, required %h at cycle %0d", rd_data, cyc, e, d);
                end
            end
        end
        if (qs_due.size() > 0 && qs_due[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL rd_missing: got no rd_valid, required %h at cycle %0d", qs_data[0], qs_due[0]);
            void'(qs_due.pop_front());
            void'(qs_data.pop_front());
        end
    end

    task automatic idle();
        rd_req = 1'b0; rd_addr = '0; vrd_req = 1'b0; vrd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        vwr_en = 1'b0; vwr_addr = '0; vwr_mask = '0; vwr_data = '0;
    endtask

    // Runs one clock with the current inputs. Checks ready, queues expected reads, updates the model, checks the counter.
    task automatic drive_cycle();
        logic exp_wr_ready;
        logic [31:0] vexp;
        int inc;
        #1;
        exp_wr_ready = 1'b1;
        if (vwr_en)
            for (int k = 0; k < NB; k++)
                if (vwr_mask[k] && ((int'(vwr_addr) + k) % NB) == (int'(wr_addr) % NB)) exp_wr_ready = 1'b0;
        checks++;
        if (rd_ready !== !vrd_req) begin
            errors++;
            $display("FAIL rd_ready: got %b required %b at cycle %0d", rd_ready, !vrd_req, cyc);
        end
        checks++;
        if (wr_ready !== exp_wr_ready) begin
            errors++;
            $display("FAIL wr_ready: got %b required %b at cycle %0d", wr_ready, exp_wr_ready, cyc);
        end
        if (vrd_req) begin
            for (int k = 0; k < NB; k++) vexp[k*8 +: 8] = mem_m[(int'(vrd_addr) + k) % MS];
            qv_due.push_back(cyc + 2);
            qv_data.push_back(vexp);
        end else if (rd_req) begin
            qs_due.push_back(cyc + 2);
            qs_data.push_back(mem_m[int'(rd_addr)]);
        end
        if (vwr_en)
            for (int k = 0; k < NB; k++)
                if (vwr_mask[k]) mem_m[(int'(vwr_addr) + k) % MS] = vwr_data[k*8 +: 8];
        if (wr_en && exp_wr_ready) mem_m[int'(wr_addr)] = wr_data;
        inc = ((rd_req && vrd_req) ? 1 : 0) + ((wr_en && !exp_wr_ready) ? 1 : 0);
        if (rst) cnt_m = 0;
        else cnt_m = (cnt_m + inc > 65535) ? 65535 : cnt_m + inc;
        if (rst) begin
            qv_due.delete(); qv_data.delete(); qs_due.delete(); qs_data.delete();
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (conflict_cnt !== 16'(cnt_m)) begin
            errors++;
            $display("FAIL conflict_cnt: got %h required %h at cycle %0d", conflict_cnt, 16'(cnt_m), cyc);
        end
    endtask

    task automatic drain();
        idle();
        repeat (4) drive_cycle();
        checks++;
        if (qv_due.size() + qs_due.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding reads, required 0", qv_due.size() + qs_due.size());
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) drive_cycle();
        rst = 1'b0;
        checks++;
        if ({rd_valid, vrd_valid, rd_data, vrd_data, conflict_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got rv=%b vv=%b rd=%h vd=%h cnt=%h required all zero",
                     rd_valid, vrd_valid, rd_data, vrd_data, conflict_cnt);
        end
    endtask

    task automatic test_scalar();
        for (int a = 0; a < 16; a++) begin
            idle(); wr_en = 1'b1; wr_addr = AW'(a); wr_data = 8'(a + 16);
            drive_cycle();
        end
        idle(); rd_req = 1'b1; rd_addr = 18'd5;
        drive_cycle();
        drain();
    endtask

    task automatic test_simd_rw();
        idle(); vwr_en = 1'b1; vwr_addr = 18'h6; vwr_mask = 4'b1111; vwr_data = 32'hD3C2B1A0;
        drive_cycle();
        for (int a = 6; a < 10; a++) begin
            idle(); rd_req = 1'b1; rd_addr = AW'(a);
            drive_cycle();
        end
        idle(); vrd_req = 1'b1; vrd_addr = 18'h6;
        drive_cycle();
        // Read while rewriting the same pixels: the old data must come back, then the new data.
        vwr_en = 1'b1; vwr_addr = 18'h6; vwr_mask = 4'b1111; vwr_data = 32'h44332211;
        drive_cycle();
        idle(); vrd_req = 1'b1; vrd_addr = 18'h6;
        drive_cycle();
        drain();
    endtask

    task automatic test_wr_conflict();
        idle(); vwr_en = 1'b1; vwr_addr = 18'h8; vwr_mask = 4'b0101; vwr_data = 32'hE3E2E1E0;
        wr_en = 1'b1; wr_addr = 18'h9; wr_data = 8'h99;
        drive_cycle();
        wr_addr = 18'h8; wr_data = 8'h88;
        drive_cycle();
        vwr_en = 1'b0;
        drive_cycle();
        checks++;
        if (conflict_cnt !== 16'd1) begin
            errors++;
            $display("FAIL wr_conflict_cnt: got %h required 0001", conflict_cnt);
        end
        idle(); vrd_req = 1'b1; vrd_addr = 18'h8;
        drive_cycle();
        drain();
    endtask

    task automatic test_arb();
        idle(); vrd_req = 1'b1; vrd_addr = 18'h0; rd_req = 1'b1; rd_addr = 18'd3;
        repeat (3) drive_cycle();
        vrd_req = 1'b0;
        drive_cycle();
        checks++;
        if (conflict_cnt !== 16'd4) begin
            errors++;
            $display("FAIL arb_conflict_cnt: got %h required 0004", conflict_cnt);
        end
        drain();
    endtask

    task automatic test_wrap();
        idle(); vwr_en = 1'b1; vwr_addr = AW'(MS - 2); vwr_mask = 4'b1111; vwr_data = 32'h64636261;
        drive_cycle();
        idle(); vrd_req = 1'b1; vrd_addr = AW'(MS - 2);
        drive_cycle();
        idle(); rd_req = 1'b1; rd_addr = 18'd0;
        drive_cycle();
        rd_addr = 18'd1;
        drive_cycle();
        drain();
    endtask

    task automatic test_reset_flush();
        idle(); vrd_req = 1'b1; vrd_addr = 18'h4;
        drive_cycle();
        idle(); rst = 1'b1;
        drive_cycle();
        rst = 1'b0;
        checks++;
        if ({rd_valid, vrd_valid, rd_data, vrd_data} !== '0) begin
            errors++;
            $display("FAIL flush_state: got rv=%b vv=%b rd=%h vd=%h required all zero",
                     rd_valid, vrd_valid, rd_data, vrd_data);
        end
        repeat (3) drive_cycle();
        vrd_req = 1'b1; vrd_addr = 18'h4;
        drive_cycle();
        drain();
    endtask

    task automatic test_saturate();
        idle();
        vrd_req = 1'b1; vrd_addr = 18'h0; rd_req = 1'b1; rd_addr = 18'd5;
        vwr_en = 1'b1; vwr_addr = 18'h100; vwr_mask = 4'b1111; vwr_data = 32'h5A5A5A5A;
        wr_en = 1'b1; wr_addr = 18'h100; wr_data = 8'hC3;
        repeat (32767) drive_cycle();
        checks++;
        if (conflict_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_fffe: got %h required FFFE", conflict_cnt);
        end
        rd_req = 1'b0; vrd_req = 1'b0;
        drive_cycle();
        drive_cycle();
        checks++;
        if (conflict_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_ffff: got %h required FFFF", conflict_cnt);
        end
        drain();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_scalar();
        test_simd_rw();
        test_wr_conflict();
        test_arb();
        test_wrap();
        test_reset_flush();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
